gcm_instance_sequencer: RTL and testbench

Controller sitting in front of the AES-GCM pipeline: accepts one instance descriptor (IV, AAD block count, plaintext block count), then streams that instance's AAD blocks, plaintext blocks and the closing length block into the pipeline one beat per cycle. It generates the `new_instance` and `pt_instance` marker pulses and the constant `instance_size` word that the downstream stages consume. It also owns data-input flow control, since the pipeline itself has no backpressure.

---
 rtl/gcm_instance_sequencer_if.sv | 37 +++
 rtl/gcm_instance_sequencer.sv | 116 +++++++++++
 tb/tb_gcm_instance_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gcm_instance_sequencer_if.sv
// Descriptor, data-input and pipeline-beat bundle for gcm_instance_sequencer.
// slave = sequencer side, master = descriptor/data source and beat consumer.
interface gcm_instance_sequencer_if #(parameter int CNT_W = 16);
  logic             i_desc_valid;
  logic             o_desc_ready;
  logic [95:0]      i_desc_iv;
  logic [CNT_W-1:0] i_desc_aad_blocks;
  logic [CNT_W-1:0] i_desc_pt_blocks;
  logic             i_data_valid;
  logic             o_data_ready;
  logic [127:0]     i_data;
  logic             o_valid;
  logic [95:0]      o_iv;
  logic [127:0]     o_aad;
  logic [127:0]     o_plain_text;
  logic [127:0]     o_instance_size;
  logic             o_new_instance;
  logic             o_pt_instance;
  logic             o_last;
  logic             o_busy;

  modport slave (
    input  i_desc_valid, i_desc_iv, i_desc_aad_blocks, i_desc_pt_blocks,
    input  i_data_valid, i_data,
    output o_desc_ready, o_data_ready,
    output o_valid, o_iv, o_aad, o_plain_text, o_instance_size,
    output o_new_instance, o_pt_instance, o_last, o_busy
  );

  modport master (
    output i_desc_valid, i_desc_iv, i_desc_aad_blocks, i_desc_pt_blocks,
    output i_data_valid, i_data,
    input  o_desc_ready, o_data_ready,
    input  o_valid, o_iv, o_aad, o_plain_text, o_instance_size,
    input  o_new_instance, o_pt_instance, o_last, o_busy
  );
endinterface

// File: rtl/gcm_instance_sequencer.sv
// Streams one AES-GCM instance (AAD, PT, length block) into the pipeline.
// Optional GCM_SEQ_PERF_EN adds saturating instance/stall counters.
module gcm_instance_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  gcm_instance_sequencer_if.slave  bus
`ifdef GCM_SEQ_PERF_EN
  ,
  output logic [31:0]              o_instance_count,
  output logic [31:0]              o_stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, AAD, PT, LEN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] aad_left, pt_left;
  logic             first_pend, pt_first_pend;
  logic             desc_hs, data_hs, emit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    desc_hs   = 1'b0;
    data_hs   = 1'b0;
    case (state)
      IDLE: begin
        desc_hs = bus.i_desc_valid;
        if (desc_hs) begin
          if (bus.i_desc_aad_blocks != '0)     state_nxt = AAD;
          else if (bus.i_desc_pt_blocks != '0) state_nxt = PT;
          else                                 state_nxt = LEN;
        end
      end
      AAD: begin
        data_hs = bus.i_data_valid;
        if (data_hs && aad_left == CNT_W'(1))
          state_nxt = (pt_left != '0) ? PT : LEN;
      end
      PT: begin
        data_hs = bus.i_data_valid;
        if (data_hs && pt_left == CNT_W'(1)) state_nxt = LEN;
      end
      LEN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready/busy decode straight from the state flop, so they are glitch-free.
  assign bus.o_desc_ready = (state == IDLE);
  assign bus.o_data_ready = (state == AAD) || (state == PT);
  assign bus.o_busy       = (state != IDLE);
  assign emit             = data_hs || (state == LEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_valid         <= 1'b0;
      bus.o_last          <= 1'b0;
      bus.o_new_instance  <= 1'b0;
      bus.o_pt_instance   <= 1'b0;
      bus.o_aad           <= '0;
      bus.o_plain_text    <= '0;
      bus.o_iv            <= '0;
      bus.o_instance_size <= '0;
      aad_left            <= '0;
      pt_left             <= '0;
      first_pend          <= 1'b0;
      pt_first_pend       <= 1'b0;
    end else begin
      bus.o_valid        <= emit;
      bus.o_last         <= (state == LEN);
      bus.o_new_instance <= emit && first_pend;
      bus.o_pt_instance  <= data_hs && (state == PT) && pt_first_pend;
      bus.o_aad          <= (data_hs && state == AAD) ? bus.i_data : '0;
      bus.o_plain_text   <= (data_hs && state == PT)  ? bus.i_data : '0;
      if (desc_hs) begin
        bus.o_iv            <= bus.i_desc_iv;
        // Block counts to bit lengths: x128 is a shift by 7.
        bus.o_instance_size <= {64'(bus.i_desc_aad_blocks) << 7,
                                64'(bus.i_desc_pt_blocks) << 7};
        aad_left            <= bus.i_desc_aad_blocks;
        pt_left             <= bus.i_desc_pt_blocks;
        first_pend          <= 1'b1;
        pt_first_pend       <= 1'b1;
      end else begin
        if (emit) first_pend <= 1'b0;
        if (data_hs && state == AAD) aad_left <= aad_left - CNT_W'(1);
        if (data_hs && state == PT) begin
          pt_left       <= pt_left - CNT_W'(1);
          pt_first_pend <= 1'b0;
        end
      end
    end
  end

`ifdef GCM_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_instance_count <= '0;
      o_stall_count    <= '0;
    end else begin
      if (state == LEN && !(&o_instance_count))
        o_instance_count <= o_instance_count + 32'd1;
      if ((state == AAD || state == PT) && !bus.i_data_valid && !(&o_stall_count))
        o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gcm_instance_sequencer.sv
// Scoreboard bench: expected beats queued as data is driven, popped per o_valid beat.
module tb_gcm_instance_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcm_instance_sequencer_if #(.CNT_W(16)) bus ();

`ifdef GCM_SEQ_PERF_EN
  logic [31:0] ic, sc;
  gcm_instance_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave),
    .o_instance_count(ic), .o_stall_count(sc));
`else
  gcm_instance_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  typedef struct {
    logic [127:0] aad, pt, size;
    logic [95:0]  iv;
    logic [2:0]   mk;   // {new_instance, pt_instance, last}
  } beat_t;

  beat_t q[$];
  int ntest = 0, nfail = 0;
  int nbeats = 0, npt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (bus.o_pt_instance === 1'b1) npt++;
    if (bus.o_valid === 1'b1) begin
      nbeats++;
      if (q.size() == 0) chk("unexp_beat", 128'(bus.o_valid), 128'(0));
      else begin
        e = q.pop_front();
        chk("aad",   bus.o_aad, e.aad);
        chk("pt",    bus.o_plain_text, e.pt);
        chk("marks", 128'({bus.o_new_instance, bus.o_pt_instance, bus.o_last}), 128'(e.mk));
        chk("iv",    128'(bus.o_iv), 128'(e.iv));
        chk("size",  bus.o_instance_size, e.size);
      end
    end else if (bus.o_valid === 1'b0 &&
                 {bus.o_new_instance, bus.o_pt_instance, bus.o_last} != 3'b000)
      chk("idle_marks", 128'({bus.o_new_instance, bus.o_pt_instance, bus.o_last}), 128'(0));
  end

  // Caller is positioned just after a rising edge.
  task automatic send_desc(input logic [95:0] iv, input logic [15:0] a, p, output int waits);
    bus.i_desc_valid      = 1'b1;
    bus.i_desc_iv         = iv;
    bus.i_desc_aad_blocks = a;
    bus.i_desc_pt_blocks  = p;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_desc_ready) break;
      waits++;
    end
    if (waits == 20) chk("desc_timeout", 128'(bus.o_desc_ready), 128'(1));
    @(posedge clk); #1;
    bus.i_desc_valid = 1'b0;
  endtask

  task automatic send_data(input logic [95:0] iv, input logic [15:0] a, p,
                           input int bub_at, bub_n, abort_at);
    beat_t e;
    logic [127:0] d;
    bit first = 1'b1, ptf = 1'b1, ok;
    logic [127:0] size = {64'(a) * 64'd128, 64'(p) * 64'd128};
    for (int i = 0; i < int'(a) + int'(p); i++) begin
      if (i == abort_at) begin
        bus.i_data_valid = 1'b0;
        return;
      end
      if (i == bub_at) begin
        bus.i_data_valid = 1'b0;
        repeat (bub_n) begin @(posedge clk); #1; end
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      bus.i_data_valid = 1'b1;
      bus.i_data       = d;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.o_data_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("data_timeout", 128'(bus.o_data_ready), 128'(1));
      e.aad  = (i <  int'(a)) ? d : '0;
      e.pt   = (i >= int'(a)) ? d : '0;
      e.iv   = iv;
      e.size = size;
      e.mk   = {first, (i >= int'(a)) && ptf, 1'b0};
      if (i >= int'(a)) ptf = 1'b0;
      first = 1'b0;
      q.push_back(e);
      @(posedge clk); #1;
    end
    bus.i_data_valid = 1'b0;
    e.aad = '0; e.pt = '0; e.iv = iv; e.size = size; e.mk = {first, 1'b0, 1'b1};
    q.push_back(e);
  endtask

  task automatic run(input logic [95:0] iv, input logic [15:0] a, p,
                     input int bub_at, bub_n, input bit drain, output int waits);
    send_desc(iv, a, p, waits);
    nbeats = 0;
    npt    = 0;
    send_data(iv, a, p, bub_at, bub_n, -1);
    if (drain) begin
      for (int k = 0; k < 10; k++) begin
        if (q.size() == 0) break;
        @(negedge clk);
      end
      chk("drain",  128'(q.size()), 128'(0));
      chk("nbeats", 128'(nbeats), 128'(int'(a) + int'(p) + 1));
      chk("npt",    128'(npt), 128'(p != 0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w;
`ifdef GCM_SEQ_PERF_EN
    logic [31:0] ic0, sc0;
`endif
    bus.i_desc_valid = 1'b0; bus.i_desc_iv = '0;
    bus.i_desc_aad_blocks = '0; bus.i_desc_pt_blocks = '0;
    bus.i_data_valid = 1'b0; bus.i_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(bus.o_valid), 128'(0));
    chk("rst_busy",  128'(bus.o_busy), 128'(0));
    chk("rst_dready",128'(bus.o_data_ready), 128'(0));
    chk("rst_desc",  128'(bus.o_desc_ready), 128'(1));
    chk("rst_iv",    128'(bus.o_iv), 128'(0));
    chk("rst_size",  bus.o_instance_size, 128'(0));
    @(posedge clk); #1;

    run(96'hCAFEBABE_DEADBEEF_00000001, 16'd1, 16'd2, -1, 0, 1'b1, w);
    chk("size_tp", bus.o_instance_size, {64'h80, 64'h100});

    run(96'h1111, 16'd0, 16'd0, -1, 0, 1'b1, w);
    chk("size_zero", bus.o_instance_size, 128'(0));

`ifdef GCM_SEQ_PERF_EN
    ic0 = ic; sc0 = sc;
`endif
    run(96'h2222, 16'd0, 16'd3, 1, 2, 1'b1, w);
`ifdef GCM_SEQ_PERF_EN
    chk("stall_cnt", 128'(sc), 128'(sc0 + 32'd2));
    chk("inst_cnt",  128'(ic), 128'(ic0 + 32'd1));
`endif

    // Back-to-back: next descriptor offered during the LEN cycle.
    run(96'h3333, 16'd2, 16'd1, -1, 0, 1'b0, w);
    run(96'h4444, 16'd1, 16'd1, -1, 0, 1'b1, w);
    chk("b2b_waits", 128'(w), 128'(1));

    // Reset mid-PT after two blocks.
    send_desc(96'h5555, 16'd0, 16'd5, w);
    send_data(96'h5555, 16'd0, 16'd5, -1, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 128'(bus.o_valid), 128'(0));
    chk("mrst_last",  128'(bus.o_last), 128'(0));
    chk("mrst_busy",  128'(bus.o_busy), 128'(0));
    chk("mrst_dready",128'(bus.o_data_ready), 128'(0));
    chk("mrst_iv",    128'(bus.o_iv), 128'(0));
    chk("mrst_pt",    bus.o_plain_text, 128'(0));
    chk("mrst_size",  bus.o_instance_size, 128'(0));
    repeat (6) @(negedge clk);
    chk("mrst_q", 128'(q.size()), 128'(0));
    @(posedge clk); #1;

    run(96'h6666, 16'd2, 16'd0, -1, 0, 1'b1, w);
    run(96'h7777, 16'd3, 16'd2, 2, 1, 1'b1, w);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
